// File: rtl/snn_pkg.sv
// Shared definitions for the spiking encoder blocks:
// LFSR taps, default seed and the encoder FSM state type.
package snn_pkg;

  localparam logic [15:0] LFSR_TAPS    = 16'h080B;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // An all-zero LFSR would lock up, so zero maps to one.
  function automatic logic [15:0] fix_seed(
    input logic [15:0] s
  );
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/prng16.sv
// 16-bit right-shifting Fibonacci LFSR with load and step enable.
// Load has priority over step.
module prng16
  import snn_pkg::*;
#(
  parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        step,
  output logic [15:0] value
);

  logic fb;

  assign fb = ^(value & LFSR_TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= fix_seed(RESET_SEED);
    end else if (load) begin
      value <= fix_seed(load_value);
    end else if (step) begin
      value <= {fb, value[15:1]};
    end
  end

endmodule

// File: rtl/poisson_encoder.sv
// Rate-to-spike encoder: one rate word becomes NUM_STEPS
// Bernoulli spike beats, p = rate/256, driven by a shared LFSR.
module poisson_encoder
  import snn_pkg::*;
#(
  parameter int unsigned NUM_STEPS  = 16,
  parameter logic [15:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_rate,
  output logic        spike_valid,
  input  logic        spike_ready,
  output logic        spike,
  output logic [15:0] step_idx,
  input  logic        abort,
  output logic        done
);

  localparam logic [15:0] LAST = 16'(NUM_STEPS - 1);

  state_t      state;
  logic [7:0]  rate_reg;
  logic [15:0] lfsr;
  logic        accept;
  logic        lfsr_load;
  logic        lfsr_step;

  assign in_ready    = (state == IDLE);
  assign spike_valid = (state == RUN);
  assign accept      = spike_valid & spike_ready;
  assign lfsr_load   = in_ready & seed_load;
  // An aborted beat leaves the LFSR where it was.
  assign lfsr_step   = accept & ~abort;
  assign spike       = spike_valid & (lfsr[7:0] < rate_reg);

  prng16 #(
    .RESET_SEED(RESET_SEED)
  ) u_prng (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (lfsr_load),
    .load_value(seed),
    .step      (lfsr_step),
    .value     (lfsr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rate_reg <= 8'd0;
      step_idx <= 16'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            rate_reg <= in_rate;
            step_idx <= 16'd0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
          end else if (spike_ready) begin
            if (step_idx == LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              step_idx <= step_idx + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/poisson_encoder.md
POISSON_ENCODER -- requirements
Module: poisson_encoder

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 16, meaning output beats (timesteps) per encoding window, legal range 1..65535.
REQ-002 SHALL have parameter RESET_SEED, default 16'hACE1, meaning the LFSR state loaded at reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 SHALL have port seed_load  input  1  load seed into LFSR; honoured in IDLE only.
REQ-006 SHALL have port seed  input  16  seed value for seed_load.
REQ-007 SHALL have port in_valid  input  1  rate word offered.
REQ-008 SHALL have port in_ready  output  1  encoder accepts a rate word.
REQ-009 SHALL have port in_rate  input  8  spike rate; probability per step = in_rate/256.
REQ-010 SHALL have port spike_valid  output  1  spike beat offered.
REQ-011 SHALL have port spike_ready  input  1  downstream accepts beat.
REQ-012 SHALL have port spike  output  1  spike bit of the current beat.
REQ-013 SHALL have port step_idx  output  16  index of the current beat, 0..NUM_STEPS-1.
REQ-014 SHALL have port abort  input  1  terminate window immediately.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last beat of a window is accepted.

Function
REQ-016 SHALL implement FSM states IDLE and RUN; in_ready = (state==IDLE), spike_valid = (state==RUN).
REQ-017 IDLE->RUN when in_valid&in_ready; in_rate latched into rate_reg, step_idx cleared to 0; first spike_valid in the following cycle (latency 1).
REQ-018 In RUN, spike SHALL equal (lfsr[7:0] < rate_reg), combinational from registers only.
REQ-019 A beat is accepted when spike_valid&spike_ready; only then SHALL the LFSR advance one step and step_idx increment.
REQ-020 The LFSR SHALL shift right by one with new bit[15] = XOR of bits 0,1,3,11 (tap mask 16'h080B).
REQ-021 Acceptance with step_idx==NUM_STEPS-1 SHALL move to IDLE, pulse done the next cycle, leave step_idx at NUM_STEPS-1.
REQ-022 spike_valid low with spike_ready high, or spike_ready low in RUN: spike, step_idx, LFSR held stable.
REQ-023 abort in RUN SHALL move to IDLE next cycle, no done pulse, LFSR not advanced even if a beat is accepted the same cycle; abort in IDLE ignored.
REQ-024 seed_load in IDLE SHALL load seed into LFSR next cycle; seed 16'h0000 loaded as 16'h0001; seed_load in RUN ignored.
REQ-025 seed_load and in_valid in the same IDLE cycle: both honoured; the window starts from the newly loaded seed.
REQ-026 in_rate 0 SHALL yield no spikes; in_rate 255 spikes except when lfsr[7:0]==255.
REQ-027 The LFSR SHALL never reach all-zero and SHALL persist across windows (not reseeded per window).

Reset
REQ-028 On rst_n low: state IDLE, LFSR=RESET_SEED (16'h0001 if zero), rate_reg=0, step_idx=0, done=0, spike_valid=0, spike=0, in_ready=1.
REQ-029 Reset mid-window SHALL discard the window with no done pulse; operation resumes on the first clock edge after rst_n deasserts.

Structure
REQ-030 Shared package snn_pkg SHALL hold LFSR_TAPS (16'h080B), DEFAULT_SEED (16'hACE1), and the FSM state type.
REQ-031 LFSR SHALL be a sub-module prng16 (load, load value, step enable, 16-bit state out); FSM, counter and comparator stay in poisson_encoder.

Verification
REQ-032 Reset, seed 16'hACE1, in_rate 226, spike_ready=1 -> beat0 spike=1 (lfsr low byte 0xE1), beat1 LFSR=16'h5670, spike=1 (0x70<226).
REQ-033 Same seed, in_rate 225 -> beat0 spike=0, beat1 spike=1; NUM_STEPS=16 -> exactly 16 beats, done pulses once, in_ready high after.
REQ-034 spike_ready held low 5 cycles mid-window -> spike, step_idx, LFSR unchanged for all 5 cycles.
REQ-035 abort asserted at step_idx=3 with spike_ready=1 -> IDLE next cycle, no done, next window's first beat uses LFSR state at abort.
REQ-036 seed_load with seed 16'h0000 in IDLE -> LFSR reads 16'h0001; seed_load during RUN -> LFSR sequence unaffected.
REQ-037 in_rate 0 over 1000 beats -> zero spikes; in_rate 128 over 65535 beats -> spike count 32768 +/- 1%.
